// File: rtl/sb_ctrl_pkg.sv
// Shared definitions for the MinBD side-buffer controller.
// Holds the default geometry, the flit valid-bit position and the controller FSM states.
// Also holds the helper that rotates the redirect port index.
package sb_ctrl_pkg;

    localparam int SB_FLIT_W    = 11;
    localparam int SB_VLD_BIT   = SB_FLIT_W - 1;
    localparam int SB_DEPTH     = 4;
    localparam int SB_STARVE_TH = 8;
    localparam int SB_NPORTS    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        REDIR = 2'd2
    } sb_state_t;

    // Next redirect port, wrapping at nports.
    function automatic logic [2:0] next_port(input logic [2:0] cur, input int nports);
        return (int'(cur) >= nports - 1) ? 3'd0 : cur + 3'd1;
    endfunction

endpackage

// File: rtl/sb_fifo.sv
// Purpose: DEPTH-entry register FIFO holding buffered deflected flits.
// Latency: 1 cycle push-to-head; there is no bypass when the FIFO is empty.
// Backpressure: none internally; the caller never pushes when full without popping, and never pops when empty.
// Ports: push/din write at the tail, pop advances the head, head is the oldest entry,
//        empty flags no valid head, count is the entry count 0..DEPTH.
module sb_fifo #(
    parameter int W     = 11,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               head,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage needs no reset: the empty flag masks stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/sb_ctrl.sv
// Purpose: MinBD side-buffer controller; buffers deflected flits, reinjects them, and requests redirects when starved.
// Latency: 1 cycle from accepting a flit to seeing it on reinj_flit; redirect rises one edge after starve hits STARVE_TH.
// Backpressure: defl_take drops when the buffer is full and no reinjection frees a slot in the same cycle.
// Ports: defl_flit/defl_take accept deflected flits; slot_free/inject/reinj_flit reinject the head;
//        redirect/cthulhu ask the pipeline to divert a flit from port cthulhu; occupancy is the entry count.
module sb_ctrl
    import sb_ctrl_pkg::*;
#(
    parameter int FLIT_W    = SB_FLIT_W,
    parameter int DEPTH     = SB_DEPTH,
    parameter int STARVE_TH = SB_STARVE_TH,
    parameter int NPORTS    = SB_NPORTS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [FLIT_W-1:0]          defl_flit,
    output logic                       defl_take,
    input  logic                       slot_free,
    output logic                       inject,
    output logic [FLIT_W-1:0]          reinj_flit,
    output logic                       redirect,
    output logic [2:0]                 cthulhu,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int VB = FLIT_W - 1;
    localparam int CW = $clog2(DEPTH+1);
    localparam int SW = $clog2(STARVE_TH+1);

    sb_state_t     state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [2:0]    cth_q, cth_d;

    logic [FLIT_W-1:0] head;
    logic              empty;
    logic [CW-1:0]     occ_after;

    sb_fifo #(
        .W     (FLIT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (defl_take),
        .pop   (inject),
        .din   (defl_flit),
        .head  (head),
        .empty (empty),
        .count (occupancy)
    );

    // Stale storage must never look like a live flit.
    assign reinj_flit = {head[VB] & ~empty, head[VB-1:0]};
    assign inject     = reinj_flit[VB] & slot_free;
    // A pop in the same cycle frees the slot the push needs.
    assign defl_take  = defl_flit[VB] & ((occupancy != CW'(DEPTH)) | inject);
    assign occ_after  = occupancy + CW'(defl_take) - CW'(inject);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            starve_q <= '0;
            cth_q    <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            cth_q    <= cth_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        cth_d    = cth_q;
        case (state_q)
            IDLE: begin
                starve_d = '0;
                if (occ_after != '0) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (inject) begin
                    starve_d = '0;
                    state_d  = (occ_after == '0) ? IDLE : WAIT;
                end else if (starve_q == SW'(STARVE_TH)) begin
                    // starve stays saturated while the redirect is outstanding
                    state_d = REDIR;
                end else begin
                    starve_d = starve_q + SW'(1);
                end
            end
            REDIR: begin
                if (inject) begin
                    starve_d = '0;
                    cth_d    = next_port(cth_q, NPORTS);
                    state_d  = (occ_after == '0) ? IDLE : WAIT;
                end
            end
            default: begin
                state_d  = IDLE;
                starve_d = '0;
            end
        endcase
    end

    // Both come straight from flops, so cthulhu cannot move while redirect is high.
    assign redirect = (state_q == REDIR);
    assign cthulhu  = cth_q;

endmodule

// File: tb/tb_sb_ctrl.sv
module tb_sb_ctrl;

    localparam int FW    = 11;
    localparam int DEPTH = 4;
    localparam int TH    = 8;
    localparam int NP    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [FW-1:0] defl_flit = '0;
    logic          defl_take;
    logic          slot_free = 1'b0;
    logic          inject;
    logic [FW-1:0] reinj_flit;
    logic          redirect;
    logic [2:0]    cthulhu;
    logic [2:0]    occupancy;

    int n_cmp = 0;
    int n_bad = 0;

    sb_ctrl #(
        .FLIT_W    (FW),
        .DEPTH     (DEPTH),
        .STARVE_TH (TH),
        .NPORTS    (NP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .defl_flit  (defl_flit),
        .defl_take  (defl_take),
        .slot_free  (slot_free),
        .inject     (inject),
        .reinj_flit (reinj_flit),
        .redirect   (redirect),
        .cthulhu    (cthulhu),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Buffer contents as a queue; starved = cycles the head has waited
    // since the last reinjection; m_redir/m_cth mirror the request outputs.
    logic [FW-1:0] q[$];
    int            m_starve = 0;
    bit            m_redir  = 0;
    int            m_cth    = 0;

    function automatic bit m_pop();
        return (q.size() > 0) && slot_free;
    endfunction

    function automatic bit m_take();
        return defl_flit[FW-1] && ((q.size() < DEPTH) || m_pop());
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_starve = 0;
            m_redir  = 0;
            m_cth    = 0;
        end else begin
            bit pop, take, had;
            pop  = m_pop();
            take = m_take();
            had  = q.size() > 0;
            if (m_redir) begin
                if (pop) begin
                    m_redir  = 0;
                    m_cth    = (m_cth + 1) % NP;
                    m_starve = 0;
                end
            end else if (had) begin
                if (pop)                  m_starve = 0;
                else if (m_starve == TH)  m_redir  = 1;
                else                      m_starve = m_starve + 1;
            end else begin
                m_starve = 0;
            end
            if (pop)  void'(q.pop_front());
            if (take) q.push_back(defl_flit);
        end
    end

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("defl_take", 32'(defl_take), 32'(m_take()));
            chk("inject",    32'(inject),    32'(m_pop()));
            chk("occupancy", 32'(occupancy), 32'(q.size()));
            chk("redirect",  32'(redirect),  32'(m_redir));
            chk("cthulhu",   32'(cthulhu),   32'(m_cth));
            chk("reinj_vld", 32'(reinj_flit[FW-1]), 32'(q.size() > 0));
            if (q.size() > 0) chk("reinj_flit", 32'(reinj_flit), 32'(q[0]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        defl_flit = '0;
        slot_free = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_redirect(input string nm);
        int c;
        c = 0;
        while (!redirect && c < 40) begin
            step();
            c++;
        end
        chk(nm, 32'(redirect), 32'd1);
    endtask

    initial begin
        logic [FW-1:0] f[6];
        int pct;

        do_reset();
        #1;
        chk("rst_occ",       32'(occupancy),      32'd0);
        chk("rst_redirect",  32'(redirect),       32'd0);
        chk("rst_cthulhu",   32'(cthulhu),        32'd0);
        chk("rst_reinj_vld", 32'(reinj_flit[10]), 32'd0);

        // Single push, then starve with no free slot.
        defl_flit = 11'h43F;
        slot_free = 1'b0;
        #1;
        chk("t1_take", 32'(defl_take), 32'd1);
        step();                             // push edge
        defl_flit = 11'h000;
        #1;
        chk("t1_reinj",  32'(reinj_flit), 32'h43F);
        chk("t1_occ",    32'(occupancy),  32'd1);
        chk("t1_inject", 32'(inject),     32'd0);
        for (int i = 1; i <= 8; i++) step();
        chk("t3_no_redir_e8", 32'(redirect), 32'd0);
        step();
        chk("t3_redir_e9",  32'(redirect), 32'd1);
        chk("t3_cth0",      32'(cthulhu),  32'd0);
        slot_free = 1'b1;
        #1;
        chk("t3_inject", 32'(inject), 32'd1);
        step();
        slot_free = 1'b0;
        chk("t3_redir_clr", 32'(redirect),  32'd0);
        chk("t3_cth1",      32'(cthulhu),   32'd1);
        chk("t3_occ0",      32'(occupancy), 32'd0);

        // Fill, overflow attempt, push+pop while full, drain in order.
        f[0] = 11'h401; f[1] = 11'h452; f[2] = 11'h5A3;
        f[3] = 11'h6B4; f[4] = 11'h7C5; f[5] = 11'h4D6;
        for (int i = 0; i < 4; i++) begin
            defl_flit = f[i];
            step();
        end
        chk("t2_full", 32'(occupancy), 32'd4);
        defl_flit = f[4];
        #1;
        chk("t2_full_take", 32'(defl_take), 32'd0);
        step();
        chk("t2_full_hold", 32'(occupancy), 32'd4);
        defl_flit = f[5];
        slot_free = 1'b1;
        #1;
        chk("t2_pp_take",   32'(defl_take), 32'd1);
        chk("t2_pp_inject", 32'(inject),    32'd1);
        chk("t2_pp_head",   32'(reinj_flit), 32'(f[0]));
        step();
        defl_flit = '0;
        chk("t2_pp_occ", 32'(occupancy), 32'd4);
        chk("t2_drain1", 32'(reinj_flit), 32'(f[1])); step();
        chk("t2_drain2", 32'(reinj_flit), 32'(f[2])); step();
        chk("t2_drain3", 32'(reinj_flit), 32'(f[3])); step();
        chk("t2_drain4", 32'(reinj_flit), 32'(f[5])); step();
        chk("t2_empty",  32'(occupancy), 32'd0);
        slot_free = 1'b0;

        // Redirect port rotation across episodes.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            defl_flit = 11'h400 | 11'(k);
            step();
            defl_flit = '0;
            wait_redirect("t4_redir_seen");
            chk("t4_cthulhu", 32'(cthulhu), 32'(k % 4));
            slot_free = 1'b1;
            step();
            slot_free = 1'b0;
        end

        // Asynchronous reset in the middle of a redirect.
        for (int i = 0; i < 3; i++) begin
            defl_flit = 11'h480 | 11'(i);
            step();
        end
        defl_flit = '0;
        wait_redirect("t5_redir_seen");
        chk("t5_occ3", 32'(occupancy), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_redir_async", 32'(redirect),       32'd0);
        chk("t5_occ_async",   32'(occupancy),      32'd0);
        chk("t5_vld_async",   32'(reinj_flit[10]), 32'd0);
        step();
        rst_n = 1'b1;

        // Invalid flits are never taken.
        for (int i = 0; i < 20; i++) begin
            defl_flit = 11'($urandom) & 11'h3FF;
            slot_free = 1'($urandom);
            #1;
            chk("t6_take", 32'(defl_take), 32'd0);
            step();
            chk("t6_occ", 32'(occupancy), 32'd0);
        end

        // Randomised traffic with varying reinjection pressure.
        pct = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) pct = (i / 200) % 2 == 0 ? int'($urandom_range(0, 15)) : int'($urandom_range(30, 95));
            defl_flit = 11'($urandom);
            if ($urandom_range(0, 99) < 40) defl_flit[10] = 1'b0;
            slot_free = ($urandom_range(0, 99) < pct);
            step();
        end

        defl_flit = '0;
        slot_free = 1'b0;
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sb_ctrl.md
Name: sb_ctrl

Overview:
Controller for the MinBD side buffer. Captures deflected flits into a small FIFO and reinjects them when the router pipeline has a free slot. When the buffered head is starved of a free slot for too long, it raises a redirect request and selects the input port whose flit the pipeline must divert to make room. It sits beside the permutation stage and produces the inject and port-select (cthulhu) controls plus the reinjection flit.

Parameters:
FLIT_W, 11, flit width; bit FLIT_W-1 is the valid bit, the rest is opaque payload
DEPTH, 4, FIFO entries (power of 2, >=2)
STARVE_TH, 8, consecutive starved cycles before redirect (>=1)
NPORTS, 4, router input ports available for redirection (<=8)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
defl_flit  in  FLIT_W  flit deflected this cycle, candidate for buffering
defl_take  out  1  combinational; the controller accepts defl_flit this cycle
slot_free  in  1  pipeline has an empty slot this cycle
inject  out  1  combinational; equals reinj_flit valid AND slot_free (a pop occurs)
reinj_flit  out  FLIT_W  FIFO head; valid bit forced to 0 when empty
redirect  out  1  registered; request the pipeline to divert one flit into the side buffer path
cthulhu  out  3  registered; input-port index to redirect, range 0..NPORTS-1
occupancy  out  $clog2(DEPTH+1)  current entry count

Behaviour:
- Reset (async, rst_n=0): FIFO pointers, occupancy, starve counter and cthulhu=0; redirect=0; state=IDLE. Stored flit contents are don't-care, but reinj_flit valid must read 0.
- pop = inject. push = defl_take = defl_flit[FLIT_W-1] AND (occupancy<DEPTH OR pop).
  - Full + simultaneous pop: accept the push; occupancy is unchanged.
  - Empty: no bypass. A pushed flit is first visible on reinj_flit the next cycle (latency 1).
- Pointers wrap modulo DEPTH. Occupancy changes by +1, -1 or 0 per cycle and never exceeds DEPTH or goes below 0.
- FSM states:
  - IDLE: occupancy==0; starve=0.
  - WAIT: occupancy>0. Each cycle without a pop, starve increments, saturating at STARVE_TH. A pop clears starve to 0.
  - REDIR: entered from WAIT on the cycle starve reaches STARVE_TH; redirect=1 from the next edge.
- REDIR exit:
  - On the first pop: redirect clears and starve=0.
  - cthulhu advances (cthulhu+1) mod NPORTS on that same edge.
  - Next state is IDLE if occupancy is now 0, else WAIT.
- redirect is held continuously while in REDIR. cthulhu is stable whenever redirect=1.
- Simultaneous push and pop in WAIT or REDIR is legal. The pop resets starve regardless of the push.
- Reset asserted mid-REDIR: redirect drops immediately (async) and the FIFO is flushed.
- defl_flit with valid=0 is never pushed, whatever the FIFO state.

Decomposition:
- Shared package: FLIT_W, flit valid-bit index, state enum {IDLE, WAIT, REDIR}, default DEPTH/STARVE_TH/NPORTS.
- One natural sub-module, sb_fifo: the DEPTH-entry register FIFO with pointers and occupancy. The controller holds the FSM, starve counter and cthulhu rotation.

Test Plan:
1. Reset, then defl_flit=11'h43F and slot_free=0 for one cycle: defl_take=1 that cycle; next cycle reinj_flit=11'h43F, occupancy=1, inject=0.
2. Fill to 4 with distinct flits while slot_free=0, then push a 5th with slot_free=0: defl_take=0 and occupancy stays 4. Then push a 6th with slot_free=1: defl_take=1, inject=1, occupancy stays 4, pop order FIFO.
3. One flit buffered, slot_free held 0 (STARVE_TH=8): redirect rises exactly 9 edges after the push with cthulhu=0. Assert slot_free: inject=1; next cycle redirect=0 and cthulhu=1.
4. Four consecutive redirect episodes with NPORTS=4: cthulhu sequence 0,1,2,3, then wraps to 0.
5. Assert rst_n=0 asynchronously mid-REDIR with occupancy=3: redirect and occupancy go to 0 without a clock edge; reinj_flit valid=0.
6. Stream of flits with valid bit 0 on defl_flit: defl_take=0 throughout and occupancy stays 0.
